codec_spi_target: RTL and testbench
===================================

CODEC_SPI_TARGET -- requirements
Module: codec_spi_target

Interface
REQ-001 Parameter WORDBITS, default 16, meaning bits per SPI control word: 7-bit address then 9-bit data, MSB first.
REQ-002 Parameter NREGS, default 16, meaning register file depth; address 15 is the reset register.
REQ-003 clk  input  1  system clock; must be at least 8x the spi_sck frequency.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 spi_sck  input  1  SPI clock from the initiator, asynchronous to clk.
REQ-006 spi_mosi  input  1  SPI data, asynchronous to clk.
REQ-007 cs  input  1  frame select, active-low; the rising edge latches the word.
REQ-008 wr_stb  output  1  one-cycle pulse marking each correctly sized word.
REQ-009 wr_addr  output  7  address of the last correctly sized word.
REQ-010 wr_data  output  9  data of the last correctly sized word.
REQ-011 rd_addr  input  4  register readback address.
REQ-012 rd_data  output  9  registered readback data.
REQ-013 err_stb  output  1  one-cycle pulse marking a frame whose bit count is not WORDBITS.
REQ-014 soft_rst  output  1  one-cycle pulse when the reset register is written.
REQ-015 active  output  1  bit 0 of register 9.
REQ-016 frame_cnt  output  8  count of correctly sized frames, saturating at 255.

Function
REQ-017 The block SHALL pass spi_sck, spi_mosi and cs each through a 2-flop synchronizer, then a third flop used for edge detection.
REQ-018 State machine states: IDLE, SHIFT and COMMIT.
- IDLE: synchronized cs low -> SHIFT, bit count cleared to 0.
- SHIFT: synchronized cs rising edge -> COMMIT.
- COMMIT: lasts one cycle, then goes to IDLE.
REQ-019 In SHIFT, on each synchronized spi_sck rising edge the block SHALL shift the synchronized spi_mosi into a 16-bit shift register LSB-side and increment the bit count; the count saturates at 17.
REQ-020 spi_sck edges SHALL be ignored in IDLE and COMMIT.
REQ-021 In COMMIT with bit count == WORDBITS:
- wr_stb = 1.
- wr_addr = shift[15:9] and wr_data = shift[8:0], both registered.
- frame_cnt increments, saturating at 255.
REQ-022 In COMMIT with bit count != WORDBITS (short frame, or long frame with count saturated at 17): err_stb = 1; no write, wr_addr/wr_data unchanged, frame_cnt unchanged.
REQ-023 Timing of wr_stb or err_stb: high for exactly one cycle, asserted on the 3rd clk rising edge after the first edge that samples cs high.
REQ-024 Register file write on a correctly sized word, address a:
- a < 15: reg[a] <= data.
- a == 15: all registers cleared to 0 and soft_rst pulses together with wr_stb.
- a >= NREGS: register file unchanged, wr_stb still pulses.
REQ-025 Register 15 SHALL read as 0.
REQ-026 rd_data SHALL equal reg[rd_addr] one cycle after rd_addr is presented.
REQ-027 A write and a read of the same address in the same cycle SHALL return the old value.
REQ-028 cs going low again while in COMMIT SHALL be honoured: IDLE sees cs low on the next cycle and enters SHIFT with count 0, so no frame is lost.
REQ-029 active SHALL track reg[9][0] combinationally from the register.

Reset
REQ-030 On rst low, asynchronously:
- state IDLE, bit count 0, shift register 0.
- all registers 0.
- wr_stb, err_stb, soft_rst, active = 0.
- wr_addr, wr_data, rd_data, frame_cnt = 0.
- synchronizer flops: cs stages to 1, all others to 0.
REQ-031 A frame in progress when rst asserts SHALL be discarded; after release, the block waits for a fresh cs low.

Verification
REQ-032 Send word 0x1201 (16 bits) -> one wr_stb, wr_addr=0x09, wr_data=0x001, active=1, frame_cnt=1.
REQ-033 Send 0x0C5A then 0x1E00 -> reg[6] reads 0x05A, then soft_rst and wr_stb pulse together; all registers read 0 and active=0.
REQ-034 Send 15-bit frame, then 18-bit frame -> two err_stb pulses, no wr_stb, frame_cnt unchanged, registers unchanged.
REQ-035 Send 0x4055 (address 0x20) -> wr_stb with wr_addr=0x20, wr_data=0x055; register file unchanged.
REQ-036 Assert rst after 8 bits of 0x1201, release, then send 0x1201 complete -> exactly one wr_stb; reg[9]=0x001.
REQ-037 Send 300 valid frames back-to-back with one sck period of cs high between them -> 300 wr_stb pulses, frame_cnt=255.

Source files
------------

// File: rtl/codec_spi_target.sv
// SPI control-word target: 7-bit address + 9-bit data words, MSB first, committed on cs rising edge.
// Writes a small register file with registered readback; flags mis-sized frames and counts good ones.
module codec_spi_target #(
  parameter int WORDBITS = 16,
  parameter int NREGS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       cs,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       err_stb,
  output logic       soft_rst,
  output logic       active,
  output logic [7:0] frame_cnt
);

  localparam int            CW       = $clog2(WORDBITS + 2);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WORDBITS + 1);
  localparam logic [CW-1:0] CNT_OK   = CW'(WORDBITS);
  localparam logic [6:0]    RST_ADDR = 7'd15;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                state, state_nxt;
  logic [2:0]            sck_q, mosi_q, cs_q;
  logic [CW-1:0]         bit_cnt;
  logic [WORDBITS-1:0]   shift_q;
  logic [8:0]            regs [NREGS];
  logic                  sck_rise, cs_rise;
  logic                  cnt_clr, shift_en, commit_ok, commit_err;
  logic [6:0]            new_addr;
  logic [8:0]            new_data;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign new_addr = shift_q[WORDBITS-1 -: 7];
  assign new_data = shift_q[8:0];
  assign active   = regs[9][0];

  // Two flops resynchronise, the third holds the previous value for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 3'b000;
      mosi_q <= 3'b000;
      cs_q   <= 3'b111;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      mosi_q <= {mosi_q[1:0], spi_mosi};
      cs_q   <= {cs_q[1:0], cs};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    case (state)
      IDLE: begin
        // Level check so a cs low arriving during COMMIT is still picked up here.
        if (!cs_q[1]) begin
          state_nxt = SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = sck_rise;
        if (cs_rise) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt  = IDLE;
        commit_ok  = (bit_cnt == CNT_OK);
        commit_err = (bit_cnt != CNT_OK);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[WORDBITS-2:0], mosi_q[2]};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_stb    <= 1'b0;
      err_stb   <= 1'b0;
      soft_rst  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_cnt <= '0;
    end else begin
      wr_stb   <= commit_ok;
      err_stb  <= commit_err;
      soft_rst <= commit_ok && (new_addr == RST_ADDR);
      if (commit_ok) begin
        wr_addr <= new_addr;
        wr_data <= new_data;
        if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Address 15 is never stored, so it reads back as 0; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit_ok) begin
      if (new_addr == RST_ADDR) begin
        for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (new_addr < RST_ADDR && {1'b0, new_addr} < 8'(NREGS)) begin
        regs[new_addr[AW-1:0]] <= new_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_addr != 4'd15 && {1'b0, rd_addr} < 5'(NREGS)) begin
      rd_data <= regs[rd_addr[AW-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_codec_spi_target.sv
// Directed + randomized bench for codec_spi_target against a word-level register-file model.
module tb_codec_spi_target;

  localparam int HALF = 4;   // clk cycles per half sck period (sck = clk/8)
  localparam int GAP  = 8;   // cs-high time between frames: one sck period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic       wr_stb, err_stb, soft_rst, active;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic [7:0] frame_cnt;

  codec_spi_target #(.WORDBITS(16), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .cs(cs),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .err_stb(err_stb), .soft_rst(soft_rst), .active(active),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8:0] mregs [16];
  int         exp_wr = 0, exp_err = 0, exp_soft = 0, exp_fc = 0;
  logic [6:0] exp_addr = '0;
  logic [8:0] exp_data = '0;

  // Observed pulse counts
  int   wr_seen = 0, err_seen = 0, soft_seen = 0;
  logic prev_wr = 1'b0, prev_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_seen++;
      check("wr_stb_one_cycle", 32'(prev_wr), 32'd0);
    end
    if (err_stb) begin
      err_seen++;
      check("err_stb_one_cycle", 32'(prev_err), 32'd0);
    end
    if (soft_rst) begin
      soft_seen++;
      check("soft_rst_with_wr_stb", 32'(wr_stb), 32'd1);
    end
    prev_wr  = wr_stb;
    prev_err = err_stb;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = '0;
    exp_fc   = 0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic model_frame(input logic [31:0] w, input int len);
    logic [6:0] a;
    logic [8:0] d;
    if (len == 16) begin
      a = w[15:9];
      d = w[8:0];
      exp_wr++;
      exp_addr = a;
      exp_data = d;
      if (exp_fc < 255) exp_fc++;
      if (a == 7'd15) begin
        foreach (mregs[i]) mregs[i] = '0;
        exp_soft++;
      end else if (a < 7'd16) begin
        mregs[a[3:0]] = d;
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic shift_bits(input logic [31:0] w, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      spi_mosi = w[i];
      wait_clks(HALF);
      spi_sck = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int len, input bit rd_chk);
    logic [8:0] old_v, new_v;
    int lat;
    old_v = mregs[rd_addr];
    cs = 1'b0;
    wait_clks(HALF);
    shift_bits(w, len);
    wait_clks(HALF);
    cs = 1'b1;
    model_frame(w, len);
    new_v = mregs[rd_addr];
    lat = 0;
    for (int k = 1; k <= GAP; k++) begin
      @(negedge clk);
      if ((wr_stb || err_stb) && lat == 0) lat = k;
      if (rd_chk && k == 4) check("rd_same_cycle_old", 32'(rd_data), 32'(old_v));
      if (rd_chk && k == 5) check("rd_after_write_new", 32'(rd_data), 32'(new_v));
    end
    check("strobe_latency", 32'(lat), 32'd4);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_wr_count"}, 32'(wr_seen), 32'(exp_wr));
    check({tag, "_err_count"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_soft_count"}, 32'(soft_seen), 32'(exp_soft));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(exp_data));
    check({tag, "_active"}, 32'(active), 32'(mregs[9][0]));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(mregs[a]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_stb"}, 32'(wr_stb), 32'd0);
    check({tag, "_err_stb"}, 32'(err_stb), 32'd0);
    check({tag, "_soft_rst"}, 32'(soft_rst), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int base_wr, len;
    logic [31:0] w;
    model_reset();

    // Reset state
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clks(4);
    check_state("post_reset");

    // Single write to register 9 sets active
    send_frame(32'h1201, 16, 1'b0);
    check_state("w1201");
    check("w1201_active_high", 32'(active), 32'd1);
    read_all("w1201");

    // Write reg 6 while reading it back, then soft reset via address 15
    @(negedge clk);
    rd_addr = 4'd6;
    wait_clks(2);
    send_frame(32'h0C5A, 16, 1'b1);
    check_state("w0C5A");
    send_frame(32'h1E00, 16, 1'b0);
    check_state("soft_reset");
    read_all("soft_reset");

    // Mis-sized frames leave registers and counters alone
    send_frame(32'h1201, 16, 1'b0);
    send_frame(32'h0C5A, 16, 1'b0);
    send_frame(32'h2ABC, 15, 1'b0);
    send_frame(32'h3FFFF, 18, 1'b0);
    check_state("bad_len");
    read_all("bad_len");

    // Out-of-range address still strobes but writes nothing
    send_frame(32'h4055, 16, 1'b0);
    check_state("addr_20");
    read_all("addr_20");

    // Random mix of lengths and words
    for (int n = 0; n < 24; n++) begin
      w   = $urandom;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      send_frame(w, len, 1'b0);
      check_state($sformatf("rand%0d", n));
    end
    read_all("rand");

    // Reset in the middle of a frame discards it
    cs = 1'b0;
    wait_clks(HALF);
    shift_bits(32'h12, 8);
    rst = 1'b0;
    cs  = 1'b1;
    wait_clks(3);
    check_reset_outputs("mid_reset");
    model_reset();
    rst = 1'b1;
    wait_clks(6);
    base_wr = wr_seen;
    send_frame(32'h1201, 16, 1'b0);
    check("mid_reset_one_wr", 32'(wr_seen - base_wr), 32'd1);
    check_state("mid_reset");
    read_all("mid_reset");

    // 300 back-to-back random valid words: frame_cnt saturates
    base_wr = wr_seen;
    for (int n = 0; n < 300; n++) begin
      w = $urandom;
      send_frame({16'h0, w[15:0]}, 16, 1'b0);
    end
    check("burst_wr_pulses", 32'(wr_seen - base_wr), 32'd300);
    check("burst_frame_cnt", 32'(frame_cnt), 32'd255);
    check_state("burst");
    read_all("burst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
